// File: rtl/esp_frame_pkg.sv
// Shared types and constants for the ESP host-command frame path.
package esp_frame_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StLen,
        StPayload,
        StCsum
    } state_e;

    typedef logic [2:0] err_code_t;

    localparam err_code_t ERR_OK      = 3'd0;
    localparam err_code_t ERR_CSUM    = 3'd1;
    localparam err_code_t ERR_TIMEOUT = 3'd2;
    localparam err_code_t ERR_BREAK   = 3'd3;
    localparam err_code_t ERR_UART    = 3'd4;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/esp_rx_deframer_if.sv
// UART-FIFO side and payload-stream side of the ESP receive deframer.
interface esp_rx_deframer_if;

    logic [7:0] rxfifo_data;
    logic       rxfifo_not_empty;
    logic       rxfifo_read;
    logic       rxfifo_overflow;
    logic       rx_framing_error;
    logic       rx_break;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       frame_done;
    logic       frame_ok;
    logic [2:0] err_code;

    // Deframer view.
    modport master (
        input  rxfifo_data, rxfifo_not_empty, rxfifo_overflow, rx_framing_error, rx_break,
        input  out_ready,
        output rxfifo_read, out_data, out_valid, out_sop, out_eop,
        output frame_done, frame_ok, err_code
    );

    // UART / consumer view.
    modport slave (
        output rxfifo_data, rxfifo_not_empty, rxfifo_overflow, rx_framing_error, rx_break,
        output out_ready,
        input  rxfifo_read, out_data, out_valid, out_sop, out_eop,
        input  frame_done, frame_ok, err_code
    );

endinterface

// File: rtl/esp_rx_deframer.sv
// Pulls bytes from the UART FIFO, extracts SOF/LEN/payload/CSUM frames and streams the payload
// with per-frame status.
module esp_rx_deframer
    import esp_frame_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                clk,
    input logic                rst,
    esp_rx_deframer_if.master  bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       first_q, first_d;
    logic       uart_err_q, uart_err_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_sop_q, out_sop_d;
    logic       out_eop_q, out_eop_d;
    logic       done_q, done_d;
    logic       ok_q, ok_d;
    err_code_t  err_q, err_d;

    logic       in_frame;
    logic       stall;
    logic       slot_free;
    logic       brk;
    logic       tmo_hit;
    logic       abort;
    logic       uart_pulse;
    logic       sample;
    logic       read;
    logic [7:0] csum_total;

    assign in_frame   = (state_q != StHunt);
    assign stall      = out_valid_q && !bus.out_ready;
    assign slot_free  = !out_valid_q || bus.out_ready;
    assign brk        = in_frame && bus.rx_break;
    assign tmo_hit    = in_frame && !stall && (tmo_q == TMO_LAST);
    assign abort      = brk || tmo_hit;
    assign uart_pulse = bus.rx_framing_error || bus.rxfifo_overflow;
    assign sample     = pending_q && !abort;
    assign csum_total = sum_q + bus.rxfifo_data;

    // Nothing is fetched on the abort cycle, so the next frame starts from a clean FIFO position.
    assign read = !rst && !pending_q && !abort && bus.rxfifo_not_empty &&
                  ((state_q != StPayload) || slot_free);

    always_comb begin
        state_d     = state_q;
        pending_d   = read;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        first_d     = first_q;
        uart_err_d  = uart_err_q || (in_frame && uart_pulse);
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        err_d       = ERR_OK;

        if (in_frame && !stall && (tmo_q != 16'hFFFF)) begin
            tmo_d = tmo_q + 16'd1;
        end

        if (brk) begin
            state_d    = StHunt;
            done_d     = 1'b1;
            err_d      = ERR_BREAK;
            uart_err_d = 1'b0;
            tmo_d      = 16'd0;
        end else if (tmo_hit) begin
            state_d    = StHunt;
            done_d     = 1'b1;
            err_d      = ERR_TIMEOUT;
            uart_err_d = 1'b0;
            tmo_d      = 16'd0;
        end else if (sample) begin
            tmo_d = 16'd0;
            unique case (state_q)
                StHunt: begin
                    if (bus.rxfifo_data == SOF_BYTE) begin
                        state_d = StLen;
                    end
                end
                StLen: begin
                    cnt_d   = bus.rxfifo_data;
                    sum_d   = bus.rxfifo_data;
                    first_d = 1'b1;
                    state_d = (bus.rxfifo_data == 8'd0) ? StCsum : StPayload;
                end
                StPayload: begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.rxfifo_data;
                    out_sop_d   = first_q;
                    out_eop_d   = (cnt_q == 8'd1);
                    first_d     = 1'b0;
                    sum_d       = csum_total;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    state_d    = StHunt;
                    done_d     = 1'b1;
                    uart_err_d = 1'b0;
                    // A UART error pulse coinciding with the CSUM byte still taints this frame.
                    if (uart_err_q || uart_pulse) begin
                        err_d = ERR_UART;
                    end else if (csum_total == 8'd0) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = ERR_CSUM;
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            pending_q   <= 1'b0;
            cnt_q       <= 8'd0;
            sum_q       <= 8'd0;
            first_q     <= 1'b0;
            uart_err_q  <= 1'b0;
            tmo_q       <= 16'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            first_q     <= first_d;
            uart_err_q  <= uart_err_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    assign bus.rxfifo_read = read;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sop     = out_sop_q;
    assign bus.out_eop     = out_eop_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_ok    = ok_q;
    assign bus.err_code    = err_q;

endmodule

// File: tb/tb_esp_rx_deframer.sv
// Directed bench for esp_rx_deframer: table-driven frames plus hand-written backpressure,
// timeout, break and UART-error sequences.
module tb_esp_rx_deframer;
    import esp_frame_pkg::*;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    esp_rx_deframer_if bus ();

    esp_rx_deframer #(
        .SOF_BYTE       (8'h7E),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [63:0] frame;
        int          nbytes;
        int          nbeats;
        logic [31:0] payload;
        logic        ok;
        logic [2:0]  err;
    } vec_t;

    int nchecks = 0;
    int nerrs   = 0;
    int nreads  = 0;
    int underflow = 0;
    int stream_viol = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] beats[$];   // {sop, eop, data}
    logic [3:0] dones[$];   // {ok, err}
    logic       rd_seen = 1'b0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    // Monitor: everything sampled mid-cycle.
    always @(negedge clk) begin
        rd_seen = bus.rxfifo_read;
        if (bus.rxfifo_read) nreads++;
        if (prev_stall && (!bus.out_valid ||
                           {bus.out_sop, bus.out_eop, bus.out_data} != prev_beat)) begin
            stream_viol++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_beat  = {bus.out_sop, bus.out_eop, bus.out_data};
        if (bus.out_valid && bus.out_ready) beats.push_back({bus.out_sop, bus.out_eop, bus.out_data});
        if (bus.frame_done) dones.push_back({bus.frame_ok, bus.err_code});
    end

    // FIFO model: data for a read appears one cycle later.
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (fifo_q.size() == 0) underflow++;
            else bus.rxfifo_data = fifo_q.pop_front();
        end
        bus.rxfifo_not_empty = (fifo_q.size() != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " done seen"}, 32'(bus.frame_done), 1);
    endtask

    task automatic wait_beat(input string name, input logic [7:0] d, input int budget);
        int n = 0;
        while (!(bus.out_valid && bus.out_data == d) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " beat seen"}, 32'(bus.out_valid && bus.out_data == d), 1);
    endtask

    task automatic pulse(input int which);
        @(posedge clk);
        #1;
        case (which)
            0: bus.rx_break = 1'b1;
            1: bus.rx_framing_error = 1'b1;
            default: bus.rxfifo_overflow = 1'b1;
        endcase
        @(posedge clk);
        #1;
        bus.rx_break         = 1'b0;
        bus.rx_framing_error = 1'b0;
        bus.rxfifo_overflow  = 1'b0;
    endtask

    task automatic check_done(input string name, input logic ok, input logic [2:0] err);
        check({name, " ndone"}, dones.size(), 1);
        if (dones.size() > 0) begin
            check({name, " frame_ok"}, 32'(dones[0][3]), 32'(ok));
            check({name, " err_code"}, 32'(dones[0][2:0]), 32'(err));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int r0;
        logic [9:0] exp;
        beats.delete();
        dones.delete();
        r0 = nreads;
        for (int i = 0; i < v.nbytes; i++) push(v.frame[63-8*i -: 8]);
        wait_done(tag, 200);
        repeat (4) @(negedge clk);
        check({tag, " nbeats"}, beats.size(), v.nbeats);
        for (int i = 0; i < v.nbeats && i < beats.size(); i++) begin
            exp = {(i == 0), (i == v.nbeats - 1), v.payload[31-8*i -: 8]};
            check($sformatf("%s beat%0d", tag, i), 32'(beats[i]), 32'(exp));
        end
        check_done(tag, v.ok, v.err);
        check({tag, " reads"}, nreads - r0, v.nbytes);
    endtask

    vec_t vecs[5];

    initial begin
        int k;
        int r0;
        int held_bad;
        int eops;

        bus.rx_break         = 1'b0;
        bus.rx_framing_error = 1'b0;
        bus.rxfifo_overflow  = 1'b0;
        bus.out_ready        = 1'b1;

        vecs[0] = '{64'h7E03112233970000, 6, 3, 32'h11223300, 1'b1, ERR_OK};
        vecs[1] = '{64'h7E03112233980000, 6, 3, 32'h11223300, 1'b0, ERR_CSUM};
        vecs[2] = '{64'h00FF7E0000000000, 5, 0, 32'h00000000, 1'b1, ERR_OK};
        vecs[3] = '{64'h7E017E8100000000, 4, 1, 32'h7E000000, 1'b1, ERR_OK};
        vecs[4] = '{64'h7E020102FB000000, 5, 2, 32'h01020000, 1'b1, ERR_OK};

        repeat (3) @(negedge clk);
        check("rst rxfifo_read", 32'(bus.rxfifo_read), 0);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst out_data", 32'(bus.out_data), 0);
        check("rst sop/eop", 32'({bus.out_sop, bus.out_eop}), 0);
        check("rst frame_done", 32'(bus.frame_done), 0);
        check("rst frame_ok", 32'(bus.frame_ok), 0);
        check("rst err_code", 32'(bus.err_code), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Break and UART errors are ignored while hunting.
        pulse(0);
        pulse(2);
        run_vec(vecs[0], "idle pulses");

        // Backpressure on the second beat.
        beats.delete();
        dones.delete();
        for (int i = 0; i < 6; i++) push(vecs[0].frame[63-8*i -: 8]);
        wait_beat("bp 11", 8'h11, 100);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp 22 valid", 32'(bus.out_valid), 1);
        r0 = nreads;
        held_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data != 8'h22 || bus.out_eop) held_bad++;
        end
        check("bp held", held_bad, 0);
        check("bp no reads", nreads - r0, 0);
        check("bp no done", dones.size(), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done("bp", 100);
        repeat (4) @(negedge clk);
        check("bp nbeats", beats.size(), 3);
        check_done("bp", 1'b1, ERR_OK);

        // Inter-byte timeout after the first payload byte.
        beats.delete();
        dones.delete();
        push(8'h7E);
        push(8'h05);
        push(8'hAA);
        wait_beat("tmo AA", 8'hAA, 100);
        check("tmo AA sop", 32'(bus.out_sop), 1);
        k = 0;
        while (!bus.frame_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("tmo latency", k, TMO);
        repeat (4) @(negedge clk);
        check("tmo nbeats", beats.size(), 1);
        check_done("tmo", 1'b0, ERR_TIMEOUT);
        run_vec(vecs[0], "after tmo");

        // Break mid-payload.
        beats.delete();
        dones.delete();
        push(8'h7E);
        push(8'h04);
        push(8'h01);
        push(8'h02);
        wait_beat("brk 01", 8'h01, 100);
        pulse(0);
        wait_done("brk", 50);
        repeat (4) @(negedge clk);
        check_done("brk", 1'b0, ERR_BREAK);
        eops = 0;
        foreach (beats[i]) if (beats[i][8]) eops++;
        check("brk no eop", eops, 0);
        run_vec(vecs[0], "after brk");

        // Framing error mid-payload with a correct checksum.
        beats.delete();
        dones.delete();
        for (int i = 0; i < 6; i++) push(vecs[0].frame[63-8*i -: 8]);
        wait_beat("ferr 11", 8'h11, 100);
        pulse(1);
        wait_done("ferr", 100);
        repeat (4) @(negedge clk);
        check("ferr nbeats", beats.size(), 3);
        check_done("ferr", 1'b0, ERR_UART);
        run_vec(vecs[0], "after ferr");

        check("fifo underflow", underflow, 0);
        check("stream rule", stream_viol, 0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/esp_rx_deframer.md
# esp_rx_deframer

Consumes bytes from the ESP UART receive FIFO, finds frames of the form `SOF`, `LEN`, `LEN` payload bytes, `CSUM`, and forwards the payload as a valid/ready byte stream with start/end markers. It reports a per-frame status: checksum, inter-byte timeout, line break, or UART error. It sits directly downstream of the ESP UART and drives its FIFO read strobe. It is the first stage of the host-command path.

## Interface
Parameters:
- `SOF_BYTE`, 8'h7E, start-of-frame marker.
- `TIMEOUT_CYCLES`, 65535, inter-byte timeout inside a frame, in clk cycles, 1..65535.

Ports:
- `clk`  in  1  system clock; everything is in this single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rxfifo_data`  in  8  FIFO byte; valid in the cycle after `rxfifo_read`.
- `rxfifo_not_empty`  in  1  FIFO holds at least one byte.
- `rxfifo_read`  out  1  single-cycle pop strobe.
- `rxfifo_overflow`  in  1  single-cycle pulse: a byte was lost.
- `rx_framing_error`  in  1  single-cycle UART framing-error pulse.
- `rx_break`  in  1  single-cycle break-detected pulse.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  payload beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_sop`  out  1  first payload byte of the frame; qualified by `out_valid`.
- `out_eop`  out  1  last payload byte of the frame; qualified by `out_valid`.
- `frame_done`  out  1  single-cycle pulse: frame finished or aborted.
- `frame_ok`  out  1  with `frame_done`, the frame is good.
- `err_code`  out  3  with `frame_done`: 0 ok, 1 checksum, 2 timeout, 3 break, 4 UART error.

## Operation
- **States:** `HUNT`, `LEN`, `PAYLOAD`, `CSUM`.
- **Fetch engine:** at most one read in flight.
  - `rxfifo_read` is asserted when no read is pending and `rxfifo_not_empty` is high.
  - In `PAYLOAD` it additionally requires the output slot to be free: `!out_valid` or `out_ready`.
  - The byte is sampled at the end of the cycle after the read.
- **`HUNT`:** discard bytes until `SOF_BYTE`, then go to `LEN`. A `SOF_BYTE` appearing inside `LEN`, payload or `CSUM` is plain data; there is no escaping.
- **`LEN`:** load the remaining count and initialise `sum = LEN`. `LEN` = 0 goes directly to `CSUM`. Otherwise go to `PAYLOAD`.
- **`PAYLOAD`:** load each byte into the output register.
  - `sum += byte`, count decrements.
  - `out_sop` is set on the first byte, `out_eop` on the last; both are set when `LEN` = 1.
  - After the last byte, go to `CSUM`.
- **`CSUM`:** the frame is good iff `(sum + CSUM) mod 256 == 0`. Pulse `frame_done` and return to `HUNT`.
- **UART error:** `rx_framing_error` or `rxfifo_overflow` while in `LEN`/`PAYLOAD`/`CSUM` sets a sticky flag.
  - The frame still completes.
  - At `CSUM` the result is `err_code` 4 instead of 0 or 1.
  - The flag is cleared on return to `HUNT`. These pulses are ignored in `HUNT`.
- **Break:** `rx_break` in `LEN`/`PAYLOAD`/`CSUM` aborts the frame: `frame_done`, `err_code` 3, go to `HUNT`. Any read in flight has its byte dropped. In `HUNT`, break is ignored.
- **Timeout counter:**
  - Runs in `LEN`/`PAYLOAD`/`CSUM`.
  - Clears on every byte sample and on entry to `LEN`.
  - Holds while `out_valid && !out_ready`.
  - Reaching `TIMEOUT_CYCLES` aborts with `err_code` 2. An in-flight byte is dropped.
- **Aborted frames:** a beat already held in the output register stays until accepted, per the stream rule. No `out_eop` is generated for an aborted frame; the consumer discards on `frame_done` with `!frame_ok`.
- **Simultaneous events:**
  - Break beats timeout, which beats byte sample.
  - A UART-error pulse in the same cycle as the `CSUM` sample is counted for the current frame.

## Timing
- **Reset values:** `rxfifo_read` 0, `out_valid` 0, `out_data` 0, `out_sop` 0, `out_eop` 0, `frame_done` 0, `frame_ok` 0, `err_code` 0. State `HUNT`, counters 0.
- **Read to data:** read in cycle n, data present in cycle n+1 and sampled at the end of n+1. The earliest next read is cycle n+2.
- **Data to beat:** `out_valid` rises in cycle n+2 for a payload byte read in cycle n.
- **Throughput:** peak is 1 byte per 2 cycles, far above UART rate.
- **Stream rule:**
  - Once `out_valid` is high, `out_data`, `out_sop` and `out_eop` hold until the cycle with `out_ready` high.
  - `out_valid` drops the cycle after acceptance unless a new byte is loaded.
- **Frame end:** `frame_done`, `frame_ok` and `err_code` are registered and valid for exactly the cycle n+2 after the `CSUM` read. For aborts, they are valid the cycle after the break or timeout condition.
- **Arithmetic:** `sum` is 8-bit and wraps. The count is 8-bit. The timeout counter is 16-bit and saturates.

## Structure
- **Shared package `esp_frame_pkg`:** the state enum, the `err_code` constants (`ERR_OK`/`ERR_CSUM`/`ERR_TIMEOUT`/`ERR_BREAK`/`ERR_UART`), and the default `SOF_BYTE`.
- **Module:** a single module; no sub-module is warranted. The fetch engine, FSM, output register and timeout counter are all kept local.

## Test plan
1. **Good frame:** 7E 03 11 22 33 97 -> beats 11(sop), 22, 33(eop); `frame_done` with `frame_ok`=1 and `err_code`=0.
2. **Bad checksum:** same frame with CSUM 98 -> same three beats; `frame_done` with `frame_ok`=0 and `err_code`=1.
3. **Garbage then empty frame:** 00 FF 7E 00 00 -> no beats; a single `frame_done` with ok; exactly 5 read strobes.
4. **Backpressure:** `TIMEOUT_CYCLES`=16, `out_ready` low for 40 cycles on the 22 beat -> `out_data`=22 held stable; no reads; no timeout; the frame then completes ok.
5. **Timeout:** 7E 05 AA then the FIFO stays empty, `TIMEOUT_CYCLES`=16 -> beat AA(sop); `frame_done` `err_code`=2 exactly 16 cycles after the AA sample; the following good frame parses ok.
6. **Break and UART error:**
   - `rx_break` pulse mid-payload -> `err_code`=3 and return to `HUNT`.
   - A separate frame with an `rx_framing_error` pulse mid-payload but a correct CSUM -> `err_code`=4 and `frame_ok`=0.
